// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA constants, op_sel enumeration, field positions and encoder helper
package isa_pkg;

  // Operation selector values; 16..31 are illegal
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_XOR  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_SLT  = 5'd5,
    OP_SLE  = 5'd6,
    OP_ADDI = 5'd7,
    OP_SUBI = 5'd8,
    OP_XORI = 5'd9,
    OP_ANDI = 5'd10,
    OP_ORI  = 5'd11,
    OP_LW   = 5'd12,
    OP_SW   = 5'd13,
    OP_BEQ  = 5'd14,
    OP_BNE  = 5'd15
  } op_sel_e;

  // Instruction field bit positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // R-type opcode and funct codes
  localparam logic [5:0] OPC_RTYPE  = 6'b000000;
  localparam logic [5:0] FUNCT_ADD  = 6'b000011;
  localparam logic [5:0] FUNCT_SUB  = 6'b000010;
  localparam logic [5:0] FUNCT_XOR  = 6'b000001;
  localparam logic [5:0] FUNCT_AND  = 6'b000111;
  localparam logic [5:0] FUNCT_OR   = 6'b000100;
  localparam logic [5:0] FUNCT_SLT  = 6'b110110;
  localparam logic [5:0] FUNCT_SLE  = 6'b110111;

  // I-type opcodes
  localparam logic [5:0] OPC_ADDI   = 6'b000011;
  localparam logic [5:0] OPC_SUBI   = 6'b000010;
  localparam logic [5:0] OPC_XORI   = 6'b000001;
  localparam logic [5:0] OPC_ANDI   = 6'b001111;
  localparam logic [5:0] OPC_ORI    = 6'b001100;
  localparam logic [5:0] OPC_LW     = 6'b011110;
  localparam logic [5:0] OPC_SW     = 6'b011111;
  localparam logic [5:0] OPC_BEQ    = 6'b110000;
  localparam logic [5:0] OPC_BNE    = 6'b110001;

  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_result_t;

  function automatic logic is_legal(input logic [4:0] sel);
    return (sel < 5'd16);
  endfunction

  function automatic logic is_rtype(input logic [4:0] sel);
    return (sel <= 5'd6);
  endfunction

  // Funct code for an R-type selector; zero for anything else
  function automatic logic [5:0] rtype_funct(input logic [4:0] sel);
    logic [5:0] f;
    f = 6'b000000;
    case (sel)
      OP_ADD:  f = FUNCT_ADD;
      OP_SUB:  f = FUNCT_SUB;
      OP_XOR:  f = FUNCT_XOR;
      OP_AND:  f = FUNCT_AND;
      OP_OR:   f = FUNCT_OR;
      OP_SLT:  f = FUNCT_SLT;
      OP_SLE:  f = FUNCT_SLE;
      default: f = 6'b000000;
    endcase
    return f;
  endfunction

  // Primary opcode for a selector; R-type shares OPC_RTYPE
  function automatic logic [5:0] sel_opcode(input logic [4:0] sel);
    logic [5:0] o;
    o = OPC_RTYPE;
    case (sel)
      OP_ADDI: o = OPC_ADDI;
      OP_SUBI: o = OPC_SUBI;
      OP_XORI: o = OPC_XORI;
      OP_ANDI: o = OPC_ANDI;
      OP_ORI:  o = OPC_ORI;
      OP_LW:   o = OPC_LW;
      OP_SW:   o = OPC_SW;
      OP_BEQ:  o = OPC_BEQ;
      OP_BNE:  o = OPC_BNE;
      default: o = OPC_RTYPE;
    endcase
    return o;
  endfunction

  // Build the instruction word; illegal selectors yield legal=0 and a zero word
  function automatic enc_result_t encode(
    input logic [4:0]  sel,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm
  );
    enc_result_t r;
    r.legal = is_legal(sel);
    r.word  = 32'h0;
    if (r.legal) begin
      r.word[OPCODE_MSB:OPCODE_LSB] = sel_opcode(sel);
      r.word[RS_MSB:RS_LSB]         = rs;
      r.word[RT_MSB:RT_LSB]         = rt;
      if (is_rtype(sel)) begin
        r.word[RD_MSB:RD_LSB]       = rd;
        r.word[SHAMT_MSB:SHAMT_LSB] = 5'b00000;
        r.word[FUNCT_MSB:FUNCT_LSB] = rtype_funct(sel);
      end else begin
        r.word[IMM_MSB:IMM_LSB]     = imm;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request and instruction-bus signal bundle for instr_encoder
interface instr_encoder_if;
  import isa_pkg::*;

  logic        op_valid;
  logic        op_ready;
  logic [4:0]  op_sel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] ibus;
  logic        ibus_valid;
  logic        ibus_ready;
  logic        illegal;
  logic [2:0]  count;

  // Requester / consumer side
  modport master (
    output op_valid, op_sel, rs, rt, rd, imm, ibus_ready,
    input  op_ready, ibus, ibus_valid, illegal, count
  );

  // Encoder side
  modport slave (
    input  op_valid, op_sel, rs, rt, rd, imm, ibus_ready,
    output op_ready, ibus, ibus_valid, illegal, count
  );
endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - 4-entry 32-bit word FIFO with push, pop, flush and occupancy count
module instr_fifo
  import isa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] data_i,
  input  logic        pop_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        full_o,
  output logic [2:0]  count_o
);

  logic [31:0] mem_q [FIFO_DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        push_ok;
  logic        pop_ok;

  assign full_o  = (count_q == 3'(FIFO_DEPTH));
  assign valid_o = (count_q != 3'd0);
  assign count_o = count_q;
  // Read data is forced to zero when empty so stale entries never leak out
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : 32'h0;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && valid_o;

  // Next pointers and count; flush drops everything including a same-cycle push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 3'd0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 2'd1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (!reset && !flush_i && push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - combinational instruction encoder feeding a 4-deep output FIFO
module instr_encoder
  import isa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  instr_encoder_if.slave     bus
);

  enc_result_t enc;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        illegal_q, illegal_d;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic [2:0]  fifo_count;

  // Pure combinational encode of the presented request
  always_comb begin
    enc = encode(bus.op_sel, bus.rs, bus.rt, bus.rd, bus.imm);
  end

  // Illegal requests still complete the handshake but are never enqueued
  assign accept = bus.op_valid && !full;
  assign push   = accept && enc.legal;
  assign pop    = fifo_valid && bus.ibus_ready;

  // Sticky illegal flag; only reset clears it, flush leaves it alone
  always_comb begin
    illegal_d = illegal_q;
    if (accept && !enc.legal) illegal_d = 1'b1;
  end

  // Illegal flag register
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  instr_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (enc.word),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .valid_o (fifo_valid),
    .full_o  (full),
    .count_o (fifo_count)
  );

  assign bus.op_ready   = !full;
  assign bus.ibus       = fifo_data;
  assign bus.ibus_valid = fifo_valid;
  assign bus.count      = fifo_count;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with a queue-based reference model
module tb_instr_encoder;

  logic clk;
  logic reset;
  logic flush;

  instr_encoder_if bus_if ();

  instr_encoder dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic        m_illegal = 1'b0;
  bit          model_live = 1'b0;

  int unsigned funct_tab [7] = '{3, 2, 1, 7, 4, 54, 55};
  int unsigned opc_tab   [9] = '{3, 2, 1, 15, 12, 30, 31, 48, 49};

  function automatic logic [31:0] model_word(int unsigned sel, int unsigned rs,
                                             int unsigned rt, int unsigned rd,
                                             int unsigned imm);
    int unsigned w;
    if (sel < 7)
      w = rs * (2**21) + rt * (2**16) + rd * (2**11) + funct_tab[sel];
    else
      w = opc_tab[sel - 7] * (2**26) + rs * (2**21) + rt * (2**16) + imm;
    return 32'(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge from the inputs held across it
  initial begin
    forever begin
      bit push_ok;
      bit pop_ok;
      @(posedge clk);
      if (reset) begin
        mq.delete();
        m_illegal  = 1'b0;
        model_live = 1'b1;
      end else if (model_live) begin
        push_ok = bus_if.op_valid && (mq.size() < 4);
        pop_ok  = (mq.size() > 0) && bus_if.ibus_ready;
        if (push_ok && bus_if.op_sel >= 5'd16) m_illegal = 1'b1;
        if (flush) begin
          mq.delete();
        end else begin
          if (pop_ok) void'(mq.pop_front());
          if (push_ok && bus_if.op_sel < 5'd16)
            mq.push_back(model_word(bus_if.op_sel, bus_if.rs, bus_if.rt, bus_if.rd, bus_if.imm));
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        check("m_ibus_valid", 32'(bus_if.ibus_valid), 32'(mq.size() != 0));
        check("m_ibus", bus_if.ibus, (mq.size() != 0) ? mq[0] : 32'h0);
        check("m_count", 32'(bus_if.count), 32'(mq.size()));
        check("m_op_ready", 32'(bus_if.op_ready), 32'(mq.size() != 4));
        check("m_illegal", 32'(bus_if.illegal), 32'(m_illegal));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm);
    bus_if.op_valid = 1'b1;
    bus_if.op_sel   = sel;
    bus_if.rs       = rs;
    bus_if.rt       = rt;
    bus_if.rd       = rd;
    bus_if.imm      = imm;
  endtask

  task automatic send(input logic [4:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm);
    set_op(sel, rs, rt, rd, imm);
    tick();
    bus_if.op_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus_if.op_valid   = 1'b0;
    bus_if.op_sel     = 5'd0;
    bus_if.rs         = 5'd0;
    bus_if.rt         = 5'd0;
    bus_if.rd         = 5'd0;
    bus_if.imm        = 16'h0;
    bus_if.ibus_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_count", 32'(bus_if.count), 32'd0);
    check("rst_op_ready", 32'(bus_if.op_ready), 32'd1);
    check("rst_ibus_valid", 32'(bus_if.ibus_valid), 32'd0);
    check("rst_ibus", bus_if.ibus, 32'h0);
    check("rst_illegal", 32'(bus_if.illegal), 32'd0);

    // ADD with latency 1
    send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    check("add_ibus", bus_if.ibus, 32'h00221803);
    check("add_valid", 32'(bus_if.ibus_valid), 32'd1);
    bus_if.ibus_ready = 1'b1;
    tick();
    bus_if.ibus_ready = 1'b0;

    // ADDI, BEQ, SW in order
    send(5'd7, 5'd4, 5'd5, 5'd0, 16'h0010);
    send(5'd14, 5'd1, 5'd2, 5'd0, 16'hFFFC);
    send(5'd13, 5'd3, 5'd7, 5'd0, 16'h0008);
    check("seq_count", 32'(bus_if.count), 32'd3);
    check("seq_addi", bus_if.ibus, 32'h0C850010);
    bus_if.ibus_ready = 1'b1;
    tick();
    check("seq_beq", bus_if.ibus, 32'hC022FFFC);
    tick();
    check("seq_sw", bus_if.ibus, 32'h7C670008);
    tick();
    check("seq_empty", 32'(bus_if.count), 32'd0);
    bus_if.ibus_ready = 1'b0;

    // Full and backpressure: five requests, four accepted
    set_op(5'd2, 5'd1, 5'd1, 5'd1, 16'h0); tick();
    set_op(5'd1, 5'd2, 5'd3, 5'd4, 16'h0); tick();
    set_op(5'd8, 5'd5, 5'd6, 5'd0, 16'h1234); tick();
    set_op(5'd15, 5'd7, 5'd8, 5'd0, 16'h00FF); tick();
    check("full_count", 32'(bus_if.count), 32'd4);
    check("full_op_ready", 32'(bus_if.op_ready), 32'd0);
    set_op(5'd12, 5'd9, 5'd10, 5'd0, 16'h0004); tick();
    check("full_hold_count", 32'(bus_if.count), 32'd4);
    check("full_hold_ibus", bus_if.ibus, 32'h00210801);
    bus_if.ibus_ready = 1'b1;
    tick();
    bus_if.ibus_ready = 1'b0;
    check("bp_count", 32'(bus_if.count), 32'd3);
    check("bp_op_ready", 32'(bus_if.op_ready), 32'd1);
    tick();
    check("bp_fifth_count", 32'(bus_if.count), 32'd4);
    bus_if.op_valid   = 1'b0;
    bus_if.ibus_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("bp_drained", 32'(bus_if.count), 32'd0);
    bus_if.ibus_ready = 1'b0;

    // Simultaneous push and pop at count 2 across pointer wrap
    send(5'd3, 5'd11, 5'd12, 5'd13, 16'h0);
    send(5'd10, 5'd14, 5'd15, 5'd0, 16'hABCD);
    bus_if.ibus_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_op(5'(i % 16), 5'(i + 1), 5'(31 - i), 5'(2 * i), 16'(16'h1000 + i));
      tick();
      check("pp_count", 32'(bus_if.count), 32'd2);
    end
    bus_if.op_valid = 1'b0;
    tick();
    tick();
    check("pp_drained", 32'(bus_if.count), 32'd0);
    bus_if.ibus_ready = 1'b0;

    // Illegal op_sel then a legal OR
    send(5'd20, 5'd1, 5'd2, 5'd3, 16'h0);
    check("ill_count", 32'(bus_if.count), 32'd0);
    check("ill_flag", 32'(bus_if.illegal), 32'd1);
    send(5'd4, 5'd5, 5'd6, 5'd7, 16'h0);
    check("ill_or_ibus", bus_if.ibus, 32'h00A63804);
    check("ill_flag_held", 32'(bus_if.illegal), 32'd1);

    // Flush with count 3 and a same-cycle push
    send(5'd9, 5'd1, 5'd1, 5'd0, 16'h0001);
    send(5'd11, 5'd2, 5'd2, 5'd0, 16'h0002);
    check("fl_pre_count", 32'(bus_if.count), 32'd3);
    flush = 1'b1;
    set_op(5'd0, 5'd3, 5'd3, 5'd3, 16'h0);
    tick();
    flush = 1'b0;
    bus_if.op_valid = 1'b0;
    check("fl_count", 32'(bus_if.count), 32'd0);
    check("fl_valid", 32'(bus_if.ibus_valid), 32'd0);
    check("fl_ibus", bus_if.ibus, 32'h0);
    check("fl_illegal", 32'(bus_if.illegal), 32'd1);
    tick();
    check("fl_discard", 32'(bus_if.count), 32'd0);

    // Reset with count 3 and a same-cycle push
    send(5'd5, 5'd1, 5'd2, 5'd3, 16'h0);
    send(5'd6, 5'd4, 5'd5, 5'd6, 16'h0);
    send(5'd14, 5'd7, 5'd8, 5'd0, 16'h0040);
    check("rs_pre_count", 32'(bus_if.count), 32'd3);
    reset = 1'b1;
    set_op(5'd1, 5'd9, 5'd9, 5'd9, 16'h0);
    tick();
    reset = 1'b0;
    bus_if.op_valid = 1'b0;
    check("rs_count", 32'(bus_if.count), 32'd0);
    check("rs_valid", 32'(bus_if.ibus_valid), 32'd0);
    check("rs_ibus", bus_if.ibus, 32'h0);
    check("rs_illegal", 32'(bus_if.illegal), 32'd0);
    tick();
    check("rs_discard", 32'(bus_if.count), 32'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
